gray_bus_scheduler: RTL and testbench
=====================================

// Module: gray_bus_scheduler
// PURPOSE
//  Shares one Gray-coded bus link between NREQ requesters. The link is the 8-bit
//  encoder/decoder pipeline: A -> encode register B -> decode register -> C.
//  Round-robin arbitration picks one requester per cycle and registers its word
//  onto the encoder input. Each word is tagged and returned with its requester
//  ID when it appears decoded on C. Bus bit toggles on B are counted for power
//  analysis. When idle, the encoder input is held, so the bus does not switch.
// PARAMETERS
//  W     8   data width of the bus link
//  NREQ  4   number of requesters (2..8)
//  CNTW  16  toggle counter width
// PORTS
//  ck         in   1       clock; all state updates on the rising edge
//  rst        in   1       reset; asynchronous, active-low (0 = reset)
//  req        in   NREQ    request vector, one bit per requester
//  data       in   NREQ*W  requester i's word is at data[i*W +: W]
//  pause      in   1       1 = issue no new grants; in-flight words still complete
//  gnt        out  NREQ    combinational one-hot grant; word is taken at this edge
//  enc_a      out  W       registered word driven to the encoder input A
//  enc_b      in   W       encoded bus B, fed back from the encoder
//  dec_c      in   W       decoded word C, fed back from the decoder
//  rx_valid   out  1       dec_c carries a delivered word this cycle
//  rx_id      out  IDW     requester that owns the delivered word; IDW = clog2(NREQ)
//  rx_data    out  W       equals dec_c; meaningful only while rx_valid = 1
//  clr_cnt    in   1       synchronous clear of toggle_cnt
//  toggle_cnt out  CNTW    saturating count of bit toggles on enc_b
// BEHAVIOUR
//  Reset (rst = 0, asynchronous):
//   - enc_a = 0, all pipeline valids = 0, rx_valid = 0, rx_id = 0
//   - toggle_cnt = 0, enc_b_q = 0, round-robin pointer ptr = 0
//   - gnt = 0 while rst = 0
//   - In-flight words are dropped and never reported.
//  Arbitration (combinational):
//   - If pause = 0 and req != 0: gnt = first set req bit scanning ptr, ptr+1, ...
//     mod NREQ. Otherwise gnt = 0.
//   - Grant is an acceptance: the requester drops or changes its word after the edge.
//  Issue edge E0 (gnt != 0):
//   - enc_a <= data[win]; ptr <= (win+1) mod NREQ; v1 <= 1, id1 <= win.
//  No grant: enc_a holds its value (no toggling); v1 <= 0; ptr holds.
//  Tag pipeline, matched to the link's two register stages:
//   - v1/id1 at E0, v2/id2 at E1, v3/id3 at E2.
//   - rx_valid = v3, rx_id = id3 (registered); rx_data = dec_c.
//  Latency: word granted before E0 appears on rx_* after E2 (3 edges).
//   - Throughput is 1 word per cycle; back-to-back rx_valid is legal.
//   - No backpressure: the receiver must accept every rx_valid cycle.
//  pause: blocks new grants only; up to 3 in-flight words still drain.
//   - De-asserting pause re-arbitrates from the current ptr.
//  Toggle count, every edge:
//   - enc_b_q <= enc_b
//   - toggle_cnt <= sat(toggle_cnt + popcount(enc_b ^ enc_b_q))
//   - sat clamps to 2^CNTW-1 and never wraps.
//   - If clr_cnt = 1, toggle_cnt <= 0; that cycle's increment is discarded.
//  Simultaneous events:
//   - A req bit dropping in the same cycle as its gnt is still granted.
//   - A single requester holding req gets a grant every cycle.
// STRUCTURE
//  Package gray_bus_pkg:
//   - W, NREQ, CNTW defaults
//   - clog2-based IDW constant
//   - popcount(W) function
//  Sub-module rr_arbiter (req, ptr -> one-hot gnt, win index).
//   - Pointer register stays in the top level.
//  Top level holds enc_a, the v/id pipeline, enc_b_q and the counter.
//  Encoder/decoder are instantiated at system level, not in this block.
// TESTING
//  1 rst=0 mid-stream with 3 words in flight
//    -> gnt=0, enc_a=0, rx_valid=0, toggle_cnt=0 immediately
//    -> no rx_valid for the dropped words after rst=1
//  2 req=0001, data0=8'h5A for 1 cycle
//    -> gnt=0001; enc_a=8'h5A after E0
//    -> rx_valid=1, rx_id=0, rx_data=8'h5A after E2, for exactly 1 cycle
//  3 req=1111 held, distinct data
//    -> gnt order 0,1,2,3,0,...
//    -> rx_id order 0,1,2,3 from the 3rd edge, rx_valid continuous
//  4 enc_a stepped 8'h00 -> 8'hFF -> 8'h00 (B = 00 -> 80 -> 00)
//    -> toggle_cnt = 1, then 2; idle cycles leave it at 2
//  5 pause=1 during stream of test 3
//    -> gnt=0 from that cycle, enc_a stable, exactly 3 further rx_valid
//    -> pause=0 resumes at the next requester in order
//  6 CNTW=4, toggles driven past 15
//    -> toggle_cnt sticks at 15
//    -> clr_cnt=1 together with a toggle -> toggle_cnt = 0

Source files
------------

// File: rtl/gray_bus_pkg.sv
// Shared constants and helpers for the Gray-coded bus scheduler.
package gray_bus_pkg;

  localparam int unsigned DEF_W    = 8;
  localparam int unsigned DEF_NREQ = 4;
  localparam int unsigned DEF_CNTW = 16;
  localparam int unsigned DEF_IDW  = $clog2(DEF_NREQ);
  localparam int unsigned PCW      = $clog2(DEF_W + 1);

  // Number of set bits in one bus word.
  function automatic logic [PCW-1:0] popcount(input logic [DEF_W-1:0] x);
    logic [PCW-1:0] n;
    n = '0;
    for (int unsigned i = 0; i < DEF_W; i++) n = n + PCW'(x[i]);
    return n;
  endfunction

endpackage

// File: rtl/gray_bus_scheduler_if.sv
// Requester, link-feedback and receiver signals of the bus scheduler.
interface gray_bus_scheduler_if
  import gray_bus_pkg::*;
#(
  parameter int unsigned W    = DEF_W,
  parameter int unsigned NREQ = DEF_NREQ,
  parameter int unsigned CNTW = DEF_CNTW
) ();

  localparam int unsigned IDW = $clog2(NREQ);

  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] data;
  logic              pause;
  logic [NREQ-1:0]   gnt;
  logic [W-1:0]      enc_a;
  logic [W-1:0]      enc_b;
  logic [W-1:0]      dec_c;
  logic              rx_valid;
  logic [IDW-1:0]    rx_id;
  logic [W-1:0]      rx_data;
  logic              clr_cnt;
  logic [CNTW-1:0]   toggle_cnt;

  modport master (
    output req, data, pause, enc_b, dec_c, clr_cnt,
    input  gnt, enc_a, rx_valid, rx_id, rx_data, toggle_cnt
  );

  modport slave (
    input  req, data, pause, enc_b, dec_c, clr_cnt,
    output gnt, enc_a, rx_valid, rx_id, rx_data, toggle_cnt
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or after ptr wins.
module rr_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = $clog2(NREQ)
) (
  input  logic            en,
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  win
);

  logic        found;
  int unsigned idx;

  always_comb begin
    gnt   = '0;
    win   = '0;
    found = 1'b0;
    idx   = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = 32'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (en && !found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        win      = IDW'(idx);
      end
    end
  end

endmodule

// File: rtl/gray_bus_scheduler.sv
// Round-robin scheduler sharing one Gray-coded bus link, with tag return and toggle count.
module gray_bus_scheduler
  import gray_bus_pkg::*;
#(
  parameter int unsigned W    = DEF_W,
  parameter int unsigned NREQ = DEF_NREQ,
  parameter int unsigned CNTW = DEF_CNTW
) (
  input logic                ck,
  input logic                rst,
  gray_bus_scheduler_if.slave bus
);

  localparam int unsigned IDW = $clog2(NREQ);
  localparam int unsigned SW  = CNTW + 1;

  logic [IDW-1:0]  ptr_q, win, ptr_nxt;
  logic            issue;
  logic [W-1:0]    word_sel;
  logic [W-1:0]    enc_a_q, enc_b_q;
  logic            v1_q, v2_q, v3_q;
  logic [IDW-1:0]  id1_q, id2_q, id3_q;
  logic [CNTW-1:0] cnt_q, cnt_nxt;
  logic [SW-1:0]   cnt_sum;

  // Grants are suppressed during reset and while paused.
  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .en  (rst & ~bus.pause),
    .req (bus.req),
    .ptr (ptr_q),
    .gnt (bus.gnt),
    .win (win)
  );

  assign issue    = |bus.gnt;
  assign word_sel = bus.data[win*W +: W];
  assign ptr_nxt  = (win == IDW'(NREQ - 1)) ? '0 : IDW'(win + IDW'(1));

  // Saturating toggle accumulation; clear wins over the increment.
  always_comb begin
    cnt_sum = SW'(cnt_q) + SW'(popcount(DEF_W'(bus.enc_b ^ enc_b_q)));
    cnt_nxt = cnt_sum[CNTW] ? '1 : cnt_sum[CNTW-1:0];
    if (bus.clr_cnt) cnt_nxt = '0;
  end

  always_ff @(posedge ck or negedge rst) begin
    if (!rst) begin
      enc_a_q <= '0;
      ptr_q   <= '0;
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      v3_q    <= 1'b0;
      id1_q   <= '0;
      id2_q   <= '0;
      id3_q   <= '0;
      enc_b_q <= '0;
      cnt_q   <= '0;
    end else begin
      if (issue) begin
        enc_a_q <= word_sel;
        ptr_q   <= ptr_nxt;
      end
      v1_q    <= issue;
      id1_q   <= win;
      v2_q    <= v1_q;
      id2_q   <= id1_q;
      v3_q    <= v2_q;
      id3_q   <= id2_q;
      enc_b_q <= bus.enc_b;
      cnt_q   <= cnt_nxt;
    end
  end

  assign bus.enc_a      = enc_a_q;
  assign bus.rx_valid   = v3_q;
  assign bus.rx_id      = id3_q;
  assign bus.rx_data    = bus.dec_c;
  assign bus.toggle_cnt = cnt_q;

endmodule

// File: tb/tb_gray_bus_scheduler.sv
// Directed bench for gray_bus_scheduler with a behavioural Gray encode/decode link.
module tb_gray_bus_scheduler;

  logic ck;
  logic rst;
  int   checks;
  int   failures;
  logic [7:0] words [4];

  gray_bus_scheduler_if #(.W(8), .NREQ(4), .CNTW(16)) bus ();
  gray_bus_scheduler_if #(.W(8), .NREQ(4), .CNTW(4))  bus2 ();

  gray_bus_scheduler #(.W(8), .NREQ(4), .CNTW(16)) dut (
    .ck (ck), .rst (rst), .bus (bus)
  );
  gray_bus_scheduler #(.W(8), .NREQ(4), .CNTW(4)) dut4 (
    .ck (ck), .rst (rst), .bus (bus2)
  );

  initial begin
    ck = 1'b0;
    forever #5 ck = ~ck;
  end

  function automatic logic [7:0] g2b(input logic [7:0] g);
    logic [7:0] b;
    b[7] = g[7];
    for (int i = 6; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  // Link model: encode register then decode register.
  always_ff @(posedge ck or negedge rst) begin
    if (!rst) begin
      bus.enc_b <= '0;
      bus.dec_c <= '0;
    end else begin
      bus.enc_b <= bus.enc_a ^ (bus.enc_a >> 1);
      bus.dec_c <= g2b(bus.enc_b);
    end
  end

  task automatic tick();
    @(posedge ck);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    bus.req = '0; bus.pause = 1'b0; bus.clr_cnt = 1'b0;
    bus2.clr_cnt = 1'b0; bus2.enc_b = '0;
    tick();
    tick();
    rst = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.req = 4'b1111; bus.pause = 1'b0;
    #1;
    checks += 5;
    if (bus.gnt !== 4'b0000) begin failures++; $display("FAIL reset_gnt got=%b exp=0000", bus.gnt); end
    if (bus.enc_a !== 8'h00) begin failures++; $display("FAIL reset_enc_a got=%h exp=00", bus.enc_a); end
    if (bus.rx_valid !== 1'b0) begin failures++; $display("FAIL reset_rx_valid got=%b exp=0", bus.rx_valid); end
    if (bus.rx_id !== 2'd0) begin failures++; $display("FAIL reset_rx_id got=%0d exp=0", bus.rx_id); end
    if (bus.toggle_cnt !== 16'd0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", bus.toggle_cnt); end
    tick();
    checks++;
    if (bus.gnt !== 4'b0000) begin failures++; $display("FAIL reset_gnt_edge got=%b exp=0000", bus.gnt); end
    bus.req = '0;
    rst = 1'b1;
    #1;
  endtask

  task automatic test_reset_midstream();
    int seen;
    bus.req = 4'b1111;
    tick(); tick(); tick();
    checks++;
    if (bus.rx_valid !== 1'b1) begin failures++; $display("FAIL mid_pre_valid got=%b exp=1", bus.rx_valid); end
    rst = 1'b0;
    #1;
    checks += 4;
    if (bus.gnt !== 4'b0000) begin failures++; $display("FAIL mid_gnt got=%b exp=0000", bus.gnt); end
    if (bus.enc_a !== 8'h00) begin failures++; $display("FAIL mid_enc_a got=%h exp=00", bus.enc_a); end
    if (bus.rx_valid !== 1'b0) begin failures++; $display("FAIL mid_rx_valid got=%b exp=0", bus.rx_valid); end
    if (bus.toggle_cnt !== 16'd0) begin failures++; $display("FAIL mid_cnt got=%0d exp=0", bus.toggle_cnt); end
    bus.req = '0;
    tick();
    rst = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.rx_valid === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin failures++; $display("FAIL mid_dropped got=%0d exp=0", seen); end
  endtask

  task automatic test_single_word();
    do_reset();
    bus.data = {8'h00, 8'h00, 8'h00, 8'h5A};
    bus.req = 4'b0001;
    #1;
    checks++;
    if (bus.gnt !== 4'b0001) begin failures++; $display("FAIL single_gnt got=%b exp=0001", bus.gnt); end
    tick();
    bus.req = 4'b0000;
    checks += 2;
    if (bus.enc_a !== 8'h5A) begin failures++; $display("FAIL single_enc_a got=%h exp=5a", bus.enc_a); end
    if (bus.rx_valid !== 1'b0) begin failures++; $display("FAIL single_e0_valid got=%b exp=0", bus.rx_valid); end
    tick();
    checks++;
    if (bus.rx_valid !== 1'b0) begin failures++; $display("FAIL single_e1_valid got=%b exp=0", bus.rx_valid); end
    tick();
    checks += 3;
    if (bus.rx_valid !== 1'b1) begin failures++; $display("FAIL single_e2_valid got=%b exp=1", bus.rx_valid); end
    if (bus.rx_id !== 2'd0) begin failures++; $display("FAIL single_rx_id got=%0d exp=0", bus.rx_id); end
    if (bus.rx_data !== 8'h5A) begin failures++; $display("FAIL single_rx_data got=%h exp=5a", bus.rx_data); end
    tick();
    checks++;
    if (bus.rx_valid !== 1'b0) begin failures++; $display("FAIL single_e3_valid got=%b exp=0", bus.rx_valid); end
  endtask

  task automatic test_hold_single();
    do_reset();
    bus.req = 4'b0010;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (bus.gnt !== 4'b0010) begin failures++; $display("FAIL hold_gnt[%0d] got=%b exp=0010", i, bus.gnt); end
      tick();
    end
    bus.req = '0;
  endtask

  task automatic test_toggle_count();
    do_reset();
    bus.data = {8'h00, 8'h00, 8'h00, 8'hFF};
    bus.req = 4'b0001;
    tick();
    bus.req = '0;
    tick(); tick(); tick();
    checks++;
    if (bus.toggle_cnt !== 16'd1) begin failures++; $display("FAIL toggle_first got=%0d exp=1", bus.toggle_cnt); end
    bus.data = {8'h00, 8'h00, 8'h00, 8'h00};
    bus.req = 4'b0001;
    tick();
    bus.req = '0;
    tick(); tick(); tick();
    checks++;
    if (bus.toggle_cnt !== 16'd2) begin failures++; $display("FAIL toggle_second got=%0d exp=2", bus.toggle_cnt); end
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if (bus.toggle_cnt !== 16'd2) begin failures++; $display("FAIL toggle_idle got=%0d exp=2", bus.toggle_cnt); end
  endtask

  task automatic test_back_to_back();
    int ex;
    do_reset();
    bus.data = {words[3], words[2], words[1], words[0]};
    bus.req = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      #1;
      checks++;
      if (bus.gnt !== 4'(1 << (k % 4))) begin
        failures++; $display("FAIL rr_gnt[%0d] got=%b exp=%b", k, bus.gnt, 4'(1 << (k % 4)));
      end
      tick();
      if (k >= 2) begin
        ex = (k - 2) % 4;
        checks += 3;
        if (bus.rx_valid !== 1'b1) begin failures++; $display("FAIL rr_valid[%0d] got=%b exp=1", k, bus.rx_valid); end
        if (bus.rx_id !== 2'(ex)) begin failures++; $display("FAIL rr_id[%0d] got=%0d exp=%0d", k, bus.rx_id, ex); end
        if (bus.rx_data !== words[ex]) begin failures++; $display("FAIL rr_data[%0d] got=%h exp=%h", k, bus.rx_data, words[ex]); end
      end
    end
  endtask

  task automatic test_pause();
    int seen;
    logic [7:0] held;
    bus.pause = 1'b1;
    #1;
    checks++;
    if (bus.gnt !== 4'b0000) begin failures++; $display("FAIL pause_gnt got=%b exp=0000", bus.gnt); end
    held = bus.enc_a;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (bus.rx_valid === 1'b1) seen++;
      checks++;
      if (bus.enc_a !== held) begin failures++; $display("FAIL pause_enc_a[%0d] got=%h exp=%h", i, bus.enc_a, held); end
      tick();
    end
    checks++;
    if (seen != 3) begin failures++; $display("FAIL pause_drain got=%0d exp=3", seen); end
    bus.pause = 1'b0;
    #1;
    checks++;
    if (bus.gnt !== 4'b0100) begin failures++; $display("FAIL resume_gnt got=%b exp=0100", bus.gnt); end
    tick();
    bus.req = '0;
    checks++;
    if (bus.enc_a !== words[2]) begin failures++; $display("FAIL resume_enc_a got=%h exp=%h", bus.enc_a, words[2]); end
  endtask

  task automatic test_saturate();
    do_reset();
    bus2.enc_b = 8'hFF;
    tick();
    checks++;
    if (bus2.toggle_cnt !== 4'd8) begin failures++; $display("FAIL sat_first got=%0d exp=8", bus2.toggle_cnt); end
    bus2.enc_b = 8'h00;
    tick();
    checks++;
    if (bus2.toggle_cnt !== 4'd15) begin failures++; $display("FAIL sat_clamp got=%0d exp=15", bus2.toggle_cnt); end
    bus2.enc_b = 8'hFF;
    tick();
    checks++;
    if (bus2.toggle_cnt !== 4'd15) begin failures++; $display("FAIL sat_stick got=%0d exp=15", bus2.toggle_cnt); end
    bus2.enc_b = 8'h00;
    bus2.clr_cnt = 1'b1;
    tick();
    checks++;
    if (bus2.toggle_cnt !== 4'd0) begin failures++; $display("FAIL sat_clear got=%0d exp=0", bus2.toggle_cnt); end
    bus2.clr_cnt = 1'b0;
    tick();
    checks++;
    if (bus2.toggle_cnt !== 4'd0) begin failures++; $display("FAIL sat_quiet got=%0d exp=0", bus2.toggle_cnt); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    words = '{8'h11, 8'h22, 8'h33, 8'h44};
    rst = 1'b0;
    bus.req = '0; bus.data = '0; bus.pause = 1'b0; bus.clr_cnt = 1'b0;
    bus2.req = '0; bus2.data = '0; bus2.pause = 1'b0; bus2.clr_cnt = 1'b0;
    bus2.enc_b = '0; bus2.dec_c = '0;
    bus.data = {words[3], words[2], words[1], words[0]};
    test_reset();
    test_reset_midstream();
    test_single_word();
    test_hold_single();
    test_toggle_count();
    test_back_to_back();
    test_pause();
    test_saturate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
